// File: rtl/i3c_pkg.sv
// Shared I3C types, constants and address helpers used by the target responder.
package i3c_pkg;

  localparam logic [6:0] I3C_DYNAMIC_ADDR_MIN = 7'h08;
  localparam logic [6:0] I3C_DYNAMIC_ADDR_MAX = 7'h7D;
  localparam logic [6:0] I3C_BROADCAST_ADDR   = 7'h7E;
  localparam logic [7:0] I3C_CCC_RSTDAA       = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WRITE     = 3'd3,
    ST_WRITE_ACK = 3'd4,
    ST_READ      = 3'd5,
    ST_READ_ACK  = 3'd6,
    ST_IGNORE    = 3'd7
  } i3c_tgt_state_t;

  // Broadcast is write-only; the static address only answers until a dynamic one exists.
  function automatic logic i3c_addr_match(input logic [6:0] addr, input logic rnw,
                                          input logic dyn_vld, input logic [6:0] dyn,
                                          input logic [6:0] static_addr);
    return ((addr == I3C_BROADCAST_ADDR) && !rnw) ||
           (dyn_vld && (addr == dyn)) ||
           (!dyn_vld && (addr == static_addr));
  endfunction

  function automatic logic i3c_da_legal(input logic [6:0] addr);
    return (addr >= I3C_DYNAMIC_ADDR_MIN) && (addr <= I3C_DYNAMIC_ADDR_MAX);
  endfunction

endpackage

// File: rtl/i3c_target_responder_if.sv
// Bus pins and byte-level data handshakes between the controller side and the target.
interface i3c_target_responder_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_next;
  logic [7:0] ccc_code;
  logic       ccc_valid;

  modport master (
    output scl_i, sda_i, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_next, ccc_code, ccc_valid
  );

  modport slave (
    input  scl_i, sda_i, tx_data,
    output sda_oe, rx_data, rx_valid, tx_next, ccc_code, ccc_valid
  );
endinterface

// File: rtl/i3c_bus_edge_detect.sv
// Synchronises SCL/SDA, then derives SCL edges and START/STOP conditions from a one-flop history.
module i3c_bus_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;
  logic                   scl_now_s;

  // Idle bus is high, so reset to 1 to avoid phantom edges after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
      scl_prev_r <= scl_sync_r[SYNC_STAGES-1];
      sda_prev_r <= sda_sync_r[SYNC_STAGES-1];
    end
  end

  assign scl_now_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s     = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise  = scl_now_s & ~scl_prev_r;
  assign scl_fall  = ~scl_now_s & scl_prev_r;
  assign start_det = scl_now_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_det  = scl_now_s & scl_prev_r & ~sda_prev_r & sda_s;

endmodule

// File: rtl/i3c_target_responder.sv
// I3C SDR target: address decode, write/read byte engine with 9th-bit ACK, RSTDAA and dynamic address.
module i3c_target_responder
  import i3c_pkg::*;
#(
  parameter logic [6:0] STATIC_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  i3c_target_responder_if.slave  bus,
  input  logic                   da_load,
  input  logic [6:0]             da_value,
  output logic [6:0]             dyn_addr,
  output logic                   dyn_addr_vld,
  output logic                   busy
);

  i3c_tgt_state_t state_r;
  logic [3:0]     bit_cnt_r;
  logic [7:0]     shift_r;
  logic [7:0]     tx_shift_r;
  logic           rnw_r;
  logic           bcast_r;
  logic           ccc_first_r;
  logic           sda_oe_r;
  logic [7:0]     rx_data_r;
  logic           rx_valid_r;
  logic           tx_next_r;
  logic [7:0]     ccc_code_r;
  logic           ccc_valid_r;
  logic [6:0]     dyn_addr_r;
  logic           dyn_vld_r;
  logic           busy_r;

  logic           scl_rise_s;
  logic           scl_fall_s;
  logic           sda_s;
  logic           start_s;
  logic           stop_s;
  logic [7:0]     byte_s;
  logic [3:0]     next_cnt_s;

  i3c_bus_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .scl_rise  (scl_rise_s),
    .scl_fall  (scl_fall_s),
    .sda_s     (sda_s),
    .start_det (start_s),
    .stop_det  (stop_s)
  );

  assign byte_s     = {shift_r[6:0], sda_s};
  assign next_cnt_s = (bit_cnt_r == 4'd8) ? 4'd0 : bit_cnt_r + 4'd1;

  // Protocol FSM, shifters and address registers; bus conditions outrank bit processing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'd0;
      tx_shift_r  <= 8'd0;
      rnw_r       <= 1'b0;
      bcast_r     <= 1'b0;
      ccc_first_r <= 1'b0;
      sda_oe_r    <= 1'b0;
      rx_data_r   <= 8'd0;
      rx_valid_r  <= 1'b0;
      tx_next_r   <= 1'b0;
      ccc_code_r  <= 8'd0;
      ccc_valid_r <= 1'b0;
      dyn_addr_r  <= 7'd0;
      dyn_vld_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rx_valid_r  <= 1'b0;
      tx_next_r   <= 1'b0;
      ccc_valid_r <= 1'b0;
      if (da_load && !busy_r && i3c_da_legal(da_value)) begin
        dyn_addr_r <= da_value;
        dyn_vld_r  <= 1'b1;
      end
      if (start_s) begin
        state_r   <= ST_ADDR;
        bit_cnt_r <= 4'd0;
        shift_r   <= 8'd0;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b1;
      end else if (stop_s) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b0;
      end else begin
        case (state_r)
          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= next_cnt_s;
              if (bit_cnt_r == 4'd7) begin
                if (i3c_addr_match(byte_s[7:1], byte_s[0], dyn_vld_r, dyn_addr_r, STATIC_ADDR)) begin
                  state_r     <= ST_ADDR_ACK;
                  rnw_r       <= byte_s[0];
                  bcast_r     <= (byte_s[7:1] == I3C_BROADCAST_ADDR);
                  ccc_first_r <= 1'b1;
                end else begin
                  state_r <= ST_IGNORE;
                end
              end
            end
          end
          // First fall drives ACK, second fall ends it and starts the data phase.
          ST_ADDR_ACK: begin
            if (scl_rise_s) begin
              bit_cnt_r <= next_cnt_s;
            end else if (scl_fall_s) begin
              if (!sda_oe_r) begin
                sda_oe_r <= 1'b1;
              end else if (rnw_r) begin
                tx_shift_r <= bus.tx_data;
                tx_next_r  <= 1'b1;
                sda_oe_r   <= ~bus.tx_data[7];
                state_r    <= ST_READ;
              end else begin
                sda_oe_r <= 1'b0;
                state_r  <= ST_WRITE;
              end
            end
          end
          ST_WRITE: begin
            if (scl_rise_s) begin
              shift_r   <= byte_s;
              bit_cnt_r <= next_cnt_s;
              if (bit_cnt_r == 4'd7) begin
                state_r <= ST_WRITE_ACK;
                if (!bcast_r) begin
                  rx_data_r  <= byte_s;
                  rx_valid_r <= 1'b1;
                end else if (ccc_first_r) begin
                  ccc_code_r  <= byte_s;
                  ccc_valid_r <= 1'b1;
                  ccc_first_r <= 1'b0;
                  if (byte_s == I3C_CCC_RSTDAA) begin
                    dyn_addr_r <= 7'd0;
                    dyn_vld_r  <= 1'b0;
                  end
                end
              end
            end
          end
          ST_WRITE_ACK: begin
            if (scl_rise_s) begin
              bit_cnt_r <= next_cnt_s;
            end else if (scl_fall_s) begin
              sda_oe_r <= ~sda_oe_r;
              if (sda_oe_r) begin
                state_r <= ST_WRITE;
              end
            end
          end
          ST_READ: begin
            if (scl_rise_s) begin
              bit_cnt_r <= next_cnt_s;
            end else if (scl_fall_s) begin
              if (bit_cnt_r == 4'd8) begin
                sda_oe_r <= 1'b0;
                state_r  <= ST_READ_ACK;
              end else begin
                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                sda_oe_r   <= ~tx_shift_r[6];
              end
            end
          end
          ST_READ_ACK: begin
            if (scl_rise_s) begin
              bit_cnt_r <= next_cnt_s;
              if (sda_s) begin
                state_r <= ST_IGNORE;
              end
            end else if (scl_fall_s) begin
              tx_shift_r <= bus.tx_data;
              tx_next_r  <= 1'b1;
              sda_oe_r   <= ~bus.tx_data[7];
              state_r    <= ST_READ;
            end
          end
          ST_IDLE, ST_IGNORE: begin
            bit_cnt_r <= 4'd0;
          end
          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
          end
        endcase
      end
    end
  end

  // Reset must free the bus immediately, not one edge later.
  assign bus.sda_oe    = sda_oe_r & ~rst;
  assign bus.rx_data   = rx_data_r;
  assign bus.rx_valid  = rx_valid_r;
  assign bus.tx_next   = tx_next_r;
  assign bus.ccc_code  = ccc_code_r;
  assign bus.ccc_valid = ccc_valid_r;
  assign dyn_addr      = dyn_addr_r;
  assign dyn_addr_vld  = dyn_vld_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_i3c_target_responder.sv
// Controller BFM with open-drain resolve and a byte scoreboard for the I3C target responder.
module tb_i3c_target_responder;
  import i3c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ctl_scl = 1'b1;
  logic       ctl_sda = 1'b1;
  logic [7:0] tx_cur = 8'h00;
  logic       da_load = 1'b0;
  logic [6:0] da_value = 7'd0;
  logic [6:0] dyn_addr;
  logic       dyn_addr_vld;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] ccc_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_exp_q[$];

  always #5 clk = ~clk;

  i3c_target_responder_if bus();

  assign bus.scl_i   = ctl_scl;
  assign bus.sda_i   = ctl_sda & ~bus.sda_oe;
  assign bus.tx_data = tx_cur;

  i3c_target_responder #(.STATIC_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .da_load      (da_load),
    .da_value     (da_value),
    .dyn_addr     (dyn_addr),
    .dyn_addr_vld (dyn_addr_vld),
    .busy         (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops expected bytes on each pulse and feeds the next read byte.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (!rst && bus.rx_valid) begin
      exp = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hDEAD;
      check_val("rx_data", 32'(bus.rx_data), exp);
    end
    if (!rst && bus.ccc_valid) begin
      exp = (ccc_q.size() > 0) ? 32'(ccc_q.pop_front()) : 32'hDEAD;
      check_val("ccc_code", 32'(bus.ccc_code), exp);
    end
    if (!rst && bus.tx_next) begin
      tx_cnt <= tx_cnt + 1;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    tx_cur <= (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    if (!ctl_scl) begin
      ctl_sda = 1'b1; tick(2);
      ctl_scl = 1'b1; tick(3);
    end
    ctl_sda = 1'b0; tick(3);
    ctl_scl = 1'b0; tick(2);
  endtask

  task automatic bus_stop_edge();
    ctl_sda = 1'b0; tick(2);
    ctl_scl = 1'b1; tick(3);
    ctl_sda = 1'b1;
  endtask

  task automatic bus_stop();
    bus_stop_edge();
    tick(5);
  endtask

  task automatic send_bit(input logic b, output logic s);
    ctl_sda = b; tick(2);
    ctl_scl = 1'b1; tick(3);
    s = bus.sda_i; tick(2);
    ctl_scl = 1'b0; tick(3);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic nack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, nack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s);
      d[i] = s;
    end
    send_bit(nack, s);
  endtask

  task automatic load_da(input logic [6:0] v);
    da_value = v; da_load = 1'b1; tick(1);
    da_load = 1'b0; tick(1);
  endtask

  initial begin
    logic       nk;
    logic       s;
    logic [7:0] d;
    int         tx0;

    tick(3);
    check_val("rst_outs", {bus.sda_oe, bus.rx_valid, bus.tx_next, bus.ccc_valid, dyn_addr_vld, busy}, 32'd0);
    check_val("rst_data", {bus.rx_data, bus.ccc_code, dyn_addr}, 32'd0);
    rst = 1'b0;
    tick(3);

    // Addressed write to the static address.
    bus_start();
    check_val("busy_start", busy, 1);
    send_byte(8'hA0, nk); check_val("wr_hdr_ack", nk, 0);
    rx_q.push_back(8'h3C);
    send_byte(8'h3C, nk); check_val("wr_b0_ack", nk, 0);
    rx_q.push_back(8'h5A);
    send_byte(8'h5A, nk); check_val("wr_b1_ack", nk, 0);
    bus_stop_edge();
    tick(1); check_val("busy_hold", busy, 1);
    tick(3); check_val("busy_drop", busy, 0);
    tick(2);
    check_val("rx_q_drained", rx_q.size(), 0);

    // Read from a freshly assigned dynamic address: ACK then NACK.
    load_da(7'h21);
    check_val("da_21", {dyn_addr_vld, dyn_addr}, {1'b1, 7'h21});
    tx_q.push_back(8'h96); rd_exp_q.push_back(8'h96);
    tx_q.push_back(8'h0F); rd_exp_q.push_back(8'h0F);
    tick(2);
    tx0 = tx_cnt;
    bus_start();
    send_byte(8'h43, nk); check_val("rd_hdr_ack", nk, 0);
    recv_byte(1'b0, d); check_val("rd_b0", d, rd_exp_q.pop_front());
    recv_byte(1'b1, d); check_val("rd_b1", d, rd_exp_q.pop_front());
    send_bit(1'b1, s); check_val("rd_after_nack_sda", s, 1);
    check_val("rd_after_nack_oe", bus.sda_oe, 0);
    send_bit(1'b1, s);
    check_val("rd_tx_next", tx_cnt - tx0, 2);
    bus_stop();

    // Static address is no longer answered once a dynamic address exists.
    bus_start();
    send_byte(8'hA0, nk); check_val("wrong_addr_nack", nk, 1);
    check_val("wrong_addr_state", dut.state_r, ST_IGNORE);
    send_byte(8'h3C, nk); check_val("ignore_nack", nk, 1);
    bus_stop();

    // Broadcast RSTDAA, a dropped trailing byte, then the static address works again.
    bus_start();
    send_byte(8'hFC, nk); check_val("bc_hdr_ack", nk, 0);
    ccc_q.push_back(8'h06);
    send_byte(8'h06, nk); check_val("bc_ccc_ack", nk, 0);
    check_val("rstdaa", dyn_addr_vld, 0);
    send_byte(8'h11, nk); check_val("bc_extra_ack", nk, 0);
    bus_stop();
    check_val("ccc_q_drained", ccc_q.size(), 0);
    bus_start();
    send_byte(8'hA0, nk); check_val("post_rstdaa_ack", nk, 0);
    bus_stop();

    // Repeated START after a partial header; the new header starts a read.
    tx_q.push_back(8'hC3); rd_exp_q.push_back(8'hC3);
    tick(2);
    tx0 = tx_cnt;
    bus_start();
    send_bit(1'b1, s); send_bit(1'b0, s); send_bit(1'b1, s);
    bus_start();
    check_val("sr_state", dut.state_r, ST_ADDR);
    send_byte(8'hA1, nk); check_val("sr_hdr_ack", nk, 0);
    recv_byte(1'b1, d); check_val("sr_rd", d, rd_exp_q.pop_front());
    check_val("sr_tx_next", tx_cnt - tx0, 1);
    bus_stop();

    // Dynamic-address range boundaries and the busy lockout.
    load_da(7'h07); check_val("da_07", dyn_addr_vld, 0);
    load_da(7'h7E); check_val("da_7e", dyn_addr_vld, 0);
    load_da(7'h08); check_val("da_08", {dyn_addr_vld, dyn_addr}, {1'b1, 7'h08});
    load_da(7'h7D); check_val("da_7d", {dyn_addr_vld, dyn_addr}, {1'b1, 7'h7D});
    bus_start();
    load_da(7'h21); check_val("da_busy", dyn_addr, 7'h7D);
    bus_stop();

    // Reset while the target drives the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hFA >> i) & 8'h01) != 8'h00, s);
    check_val("ack_driven", bus.sda_oe, 1);
    rst = 1'b1; #1;
    check_val("rst_release", bus.sda_oe, 0);
    tick(1);
    check_val("rst_mid_outs", {bus.sda_oe, bus.rx_valid, bus.tx_next, bus.ccc_valid, dyn_addr_vld, busy}, 32'd0);
    check_val("rst_mid_data", {bus.rx_data, bus.ccc_code, dyn_addr}, 32'd0);
    rst = 1'b0;
    tick(3);
    bus_start();
    send_byte(8'hA0, nk); check_val("rejoin_ack", nk, 0);
    bus_stop();
    check_val("rx_q_final", rx_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
